// File: rtl/stepmotor_pkg.sv
// Shared definitions for the stepper driver: mode codes, FSM states, coil phase table.
// Latency: n/a (package only).
// Backpressure: n/a.
package stepmotor_pkg;

    localparam logic [1:0] MODE_WAVE = 2'b00;
    localparam logic [1:0] MODE_FULL = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Eight-step half-step sequence. Even entries are two-coil (full) phases,
    // odd entries are single-coil (wave) phases. Bit order: {D, C, B, A}.
    function automatic logic [3:0] phase_coil(input logic [2:0] idx);
        logic [3:0] c;
        case (idx)
            3'd0:    c = 4'b0101;  // AC
            3'd1:    c = 4'b0001;  // A
            3'd2:    c = 4'b1001;  // DA
            3'd3:    c = 4'b1000;  // D
            3'd4:    c = 4'b1010;  // BD
            3'd5:    c = 4'b0010;  // B
            3'd6:    c = 4'b0110;  // CB
            default: c = 4'b0100;  // C
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stepmotor_ctrl_tick.sv
// Step-period divider: counts clk cycles and raises tick once per effective period.
// Latency: tick is combinational from the count; first tick max(period,2) cycles after clr drops.
// Backpressure: none; clr holds the count at zero, period changes apply immediately.
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   clr        force count to zero (takes priority over en)
//   en         count enable
//   period     cycles per tick, values below 2 behave as 2
//   tick       high for the cycle in which the count reaches the period
module step_tick #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] eff_period;

    always_comb begin
        eff_period = (period < DIV_W'(2)) ? DIV_W'(2) : period;
        // >= rather than == so that shrinking the period below the current
        // count fires on the next cycle instead of wrapping the counter.
        tick       = en && !clr && (div >= (eff_period - DIV_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= '0;
        end else if (clr) begin
            div <= '0;
        end else if (en) begin
            div <= tick ? '0 : div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/stepmotor_ctrl.sv
// 4-coil unipolar stepper driver: wave / full / half-step, run-N or continuous, signed position.
// Latency: first coil change max(period,2) cycles after start is accepted; outputs registered.
// Backpressure: none; start is ignored unless IDLE with en=1, stop/en=0 abort immediately.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   en, start, stop      enable, 1-cycle run request, abort
//   dir, mode, period    direction (1=fwd), step mode, cycles per step (live)
//   steps                step count latched at start, 0 = continuous
//   coil                 {D,C,B,A} drive
//   step_pulse, busy     1-cycle pulse per coil change, high while running
//   done, pos            1-cycle finite-run completion, signed position
module stepmotor_ctrl
    import stepmotor_pkg::*;
#(
    parameter int DIV_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] period,
    input  logic [CNT_W-1:0] steps,
    output logic [3:0]       coil,
    output logic             step_pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos
);

    state_t           state, state_n;
    logic [2:0]       idx, idx_n;
    logic [2:0]       step_sz;
    logic [CNT_W-1:0] remain, remain_n;
    logic [CNT_W-1:0] pos_n;
    logic             step_pulse_n;
    logic             done_n;
    logic             run_go;
    logic             tick;

    // Divider only advances while a run continues this cycle; any exit or
    // idle time parks it at zero so the next start sees a full period.
    assign run_go = (state == RUN) && en && !stop;

    step_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (!run_go),
        .en     (run_go),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        remain_n     = remain;
        pos_n        = pos;
        step_pulse_n = 1'b0;
        done_n       = 1'b0;
        step_sz      = 3'd1;

        case (state)
            IDLE: begin
                if (start && en && !stop) begin
                    state_n  = RUN;
                    remain_n = steps;
                end
            end
            RUN: begin
                if (!run_go) begin
                    state_n = IDLE;
                end else if (tick) begin
                    // Wave lives on odd indices, full on even. A jump of 2
                    // keeps parity; a jump of 1 realigns after a mode change.
                    case (mode)
                        MODE_HALF: step_sz = 3'd1;
                        MODE_WAVE: step_sz = idx[0] ? 3'd2 : 3'd1;
                        default:   step_sz = idx[0] ? 3'd1 : 3'd2;
                    endcase
                    idx_n        = dir ? idx + step_sz : idx - step_sz;
                    pos_n        = dir ? pos + CNT_W'(1) : pos - CNT_W'(1);
                    step_pulse_n = 1'b1;
                    // remain==0 in RUN means a continuous run.
                    if (remain != '0) begin
                        remain_n = remain - CNT_W'(1);
                        if (remain == CNT_W'(1)) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 3'd0;
            remain     <= '0;
            pos        <= '0;
            coil       <= 4'b0000;
            step_pulse <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            remain     <= remain_n;
            pos        <= pos_n;
            coil       <= en ? phase_coil(idx_n) : 4'b0000;
            step_pulse <= step_pulse_n;
            done       <= done_n;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_stepmotor_ctrl.sv
// Directed bench with a scoreboard of expected step events (cycle, coil, pos, done).
module tb_stepmotor_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, start, stop, dir;
    logic [1:0]  mode;
    logic [23:0] period;
    logic [15:0] steps;
    logic [3:0]  coil;
    logic        step_pulse, busy, done;
    logic [15:0] pos;

    typedef struct {
        int         cyc;
        logic [3:0] coil;
        logic [15:0] pos;
        logic       done;
    } ev_t;

    ev_t sb[$];
    ev_t mon_ev;
    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    int  a;

    stepmotor_ctrl #(.DIV_W(24), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .stop       (stop),
        .dir        (dir),
        .mode       (mode),
        .period     (period),
        .steps      (steps),
        .coil       (coil),
        .step_pulse (step_pulse),
        .busy       (busy),
        .done       (done),
        .pos        (pos)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] cl, input int p, input logic d);
        ev_t e;
        e.cyc  = c;
        e.coil = cl;
        e.pos  = 16'(p);
        e.done = d;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int per, input int st, output int acc);
        period = 24'(per);
        steps  = 16'(st);
        start  = 1'b1;
        step(1);
        start  = 1'b0;
        acc    = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
    endtask

    // Monitor: every coil change must match the next queued expectation.
    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_step: coil %b pos %0h at cycle %0d, none expected", coil, pos, cyc);
            end else begin
                mon_ev = sb.pop_front();
                check("step_cycle", 32'(cyc), 32'(mon_ev.cyc));
                check("step_coil", 32'(coil), 32'(mon_ev.coil));
                check("step_pos", 32'(pos), 32'(mon_ev.pos));
                check("step_done", 32'(done), 32'(mon_ev.done));
            end
        end else if (done === 1'b1) begin
            check("stray_done", 32'(done), 32'd0);
        end
    end

    logic [3:0] half_rev [8] = '{4'b0100, 4'b0110, 4'b0010, 4'b1010,
                                 4'b1000, 4'b1001, 4'b0001, 4'b0101};

    initial begin
        rst = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b1;
        mode = 2'b01; period = 24'd4; steps = 16'd3;
        step(2);
        check("rst_coil", 32'(coil), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pulse", 32'(step_pulse), 32'd0);
        check("rst_pos", 32'(pos), 32'd0);
        rst = 1'b1;
        step(2);
        check("idle_hold_coil", 32'(coil), 32'b0101);

        // 1: full-step forward, 3 steps, period 4
        start_run(4, 3, a);
        push(a + 4, 4'b1001, 1, 1'b0);
        push(a + 8, 4'b1010, 2, 1'b0);
        push(a + 12, 4'b0110, 3, 1'b1);
        check("t1_busy", 32'(busy), 32'd1);
        step(13);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_pos", 32'(pos), 32'd3);
        check("t1_coil_hold", 32'(coil), 32'b0110);

        // 2: half-step reverse, continuous, period 2
        do_reset();
        mode = 2'b10; dir = 1'b0;
        start_run(2, 0, a);
        for (int k = 1; k <= 8; k++) push(a + 2 * k, half_rev[k-1], -k, 1'b0);
        step(16);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(3);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_pos", 32'(pos), 32'h0000fff8);
        check("t2_coil", 32'(coil), 32'b0101);

        // 3: wave forward from even index, then switch to full mid-run
        do_reset();
        mode = 2'b00; dir = 1'b1;
        start_run(3, 0, a);
        push(a + 3, 4'b0001, 1, 1'b0);
        push(a + 6, 4'b1000, 2, 1'b0);
        push(a + 9, 4'b1010, 3, 1'b0);
        step(6);
        mode = 2'b01;
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        check("t3_busy", 32'(busy), 32'd0);

        // 4: en=0 mid-run aborts; same-cycle start+stop stays idle
        start_run(4, 5, a);
        push(a + 4, 4'b0110, 4, 1'b0);
        step(5);
        en = 1'b0;
        step(1);
        check("t4_en_coil", 32'(coil), 32'd0);
        check("t4_en_busy", 32'(busy), 32'd0);
        check("t4_en_done", 32'(done), 32'd0);
        en = 1'b1;
        step(1);
        check("t4_reen_coil", 32'(coil), 32'b0110);
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        check("t4_ss_busy", 32'(busy), 32'd0);
        step(4);
        check("t4_ss_busy2", 32'(busy), 32'd0);
        check("t4_ss_pos", 32'(pos), 32'd4);

        // 5: period clamping and live period reduction
        start_run(1, 2, a);
        push(a + 2, 4'b0101, 5, 1'b0);
        push(a + 4, 4'b1001, 6, 1'b1);
        step(6);
        start_run(0, 1, a);
        push(a + 2, 4'b1010, 7, 1'b1);
        step(4);
        dir = 1'b0;
        start_run(100, 1, a);
        push(a + 51, 4'b1001, 6, 1'b1);
        step(50);
        period = 24'd3;
        step(3);
        check("t5_busy", 32'(busy), 32'd0);

        // 6: synchronous reset mid-run
        dir = 1'b1;
        start_run(5, 10, a);
        push(a + 5, 4'b1010, 7, 1'b0);
        step(7);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_glitch_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        step(1);
        check("t6_rst_coil", 32'(coil), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_pulse", 32'(step_pulse), 32'd0);
        check("t6_rst_pos", 32'(pos), 32'd0);
        rst = 1'b1;
        step(3);
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_coil", 32'(coil), 32'b0101);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
